// File: rtl/uartrx_fifo_fifo_sync.sv
// Single-clock FIFO: storage, wrapping pointers and occupancy count.
// The head entry is read combinationally so callers see it without latency.
module fifo_sync #(
   parameter int DataBitWidth  = 8,
   parameter int DepthBitWidth = 4
) (
   input  logic                     rst_n,
   input  logic                     clk,
   input  logic                     push,
   input  logic [DataBitWidth-1:0]  push_data,
   input  logic                     pop,
   output logic [DataBitWidth-1:0]  head,
   output logic                     empty,
   output logic                     full,
   output logic [DepthBitWidth:0]   count
);

   localparam int Depth = 1 << DepthBitWidth;

   logic [DataBitWidth-1:0]  r_mem [Depth];
   logic [DepthBitWidth-1:0] r_wr_ptr;
   logic [DepthBitWidth-1:0] r_rd_ptr;
   logic [DepthBitWidth:0]   r_count;
   logic                     w_pop;
   logic                     w_push;

   assign empty  = (r_count == '0);
   assign full   = (r_count == (DepthBitWidth+1)'(Depth));
   assign count  = r_count;
   assign head   = r_mem[r_rd_ptr];
   assign w_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + DepthBitWidth'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + DepthBitWidth'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (DepthBitWidth+1)'(1);
            2'b01:   r_count <= r_count - (DepthBitWidth+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uartrx_fifo.sv
// UART receive buffer: runs the uartrx go/dr handshake and queues bytes,
// presenting the head byte (0 when empty) for memory-mapped reads.
module uartrx_fifo #(
   parameter int DepthBitWidth = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             rx_data,
   input  logic                   rx_dr,
   output logic                   rx_go,
   input  logic                   rd_en,
   output logic [7:0]             rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [DepthBitWidth:0] count,
   output logic                   overrun,
   input  logic                   overrun_clr
);

   typedef enum logic {
      ST_RECV,
      ST_ACK
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic       w_capture;
   logic       w_pop_ok;
   logic       w_room;
   logic       w_push;
   logic       w_drop;
   logic       r_overrun;
   logic [7:0] w_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RECV;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Capturing forces one acknowledge cycle, so each dr assertion yields one byte.
   always_comb begin
      w_state_next = r_state;
      rx_go        = 1'b1;
      w_capture    = 1'b0;
      case (r_state)
         ST_RECV: begin
            w_capture = rx_dr;
            if (rx_dr) begin
               w_state_next = ST_ACK;
            end
         end
         ST_ACK: begin
            rx_go        = 1'b0;
            w_state_next = ST_RECV;
         end
         default: w_state_next = ST_RECV;
      endcase
   end

   assign w_pop_ok = rd_en && !empty;
   assign w_room   = !full || w_pop_ok;
   assign w_push   = w_capture && w_room;
   assign w_drop   = w_capture && !w_room;

   fifo_sync #(
      .DataBitWidth  (8),
      .DepthBitWidth (DepthBitWidth)
   ) u_fifo (
      .rst_n     (rst_n),
      .clk       (clk),
      .push      (w_push),
      .push_data (rx_data),
      .pop       (rd_en),
      .head      (w_head),
      .empty     (empty),
      .full      (full),
      .count     (count)
   );

   assign rd_data = empty ? 8'h00 : w_head;

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (overrun_clr) begin
         r_overrun <= 1'b0;
      end
   end

   assign overrun = r_overrun;

endmodule

// File: tb/tb_uartrx_fifo.sv
// Scoreboard bench for uartrx_fifo: expected bytes are queued as the uartrx
// model delivers them and compared against rd_data as they are popped.
module tb_uartrx_fifo;

   localparam int Dbw   = 4;
   localparam int Depth = 1 << Dbw;

   logic           clk;
   logic           rst_n;
   logic [7:0]     rx_data;
   logic           rx_dr;
   logic           rx_go;
   logic           rd_en;
   logic [7:0]     rd_data;
   logic           empty;
   logic           full;
   logic [Dbw:0]   count;
   logic           overrun;
   logic           overrun_clr;

   int             total;
   int             bad;
   logic [7:0]     sb_q[$];
   logic           exp_overrun;

   uartrx_fifo #(.DepthBitWidth(Dbw)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_dr       (rx_dr),
      .rx_go       (rx_go),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"}, 32'(count), 32'(sb_q.size()));
      check({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
      check({tag, ".full"}, 32'(full), 32'(sb_q.size() == Depth));
      check({tag, ".rd_data"}, 32'(rd_data), 32'(sb_q.size() == 0 ? 8'h00 : sb_q[0]));
      check({tag, ".overrun"}, 32'(overrun), 32'(exp_overrun));
   endtask

   // uartrx delivers one byte; optionally a read hits in the same cycle.
   task automatic send_byte(input logic [7:0] b, input logic with_rd);
      logic       pop_ok;
      logic       room;
      logic [7:0] exp_head;
      check("send.go_idle", 32'(rx_go), 32'd1);
      pop_ok = with_rd && (sb_q.size() > 0);
      room   = (sb_q.size() < Depth) || pop_ok;
      rx_data = b;
      rx_dr   = 1'b1;
      rd_en   = with_rd;
      if (pop_ok) begin
         exp_head = sb_q.pop_front();
         check("send.pop_data", 32'(rd_data), 32'(exp_head));
      end
      if (room) sb_q.push_back(b);
      else      exp_overrun = 1'b1;
      step();
      rx_dr = 1'b0;
      rd_en = 1'b0;
      check("send.go_ack", 32'(rx_go), 32'd0);
      check_state("send");
      step();
      check("send.go_back", 32'(rx_go), 32'd1);
      $display("send %02h rd=%0d room=%0d count=%0d", b, with_rd, room, count);
   endtask

   task automatic read_byte();
      logic [7:0] exp_b;
      exp_b = (sb_q.size() == 0) ? 8'h00 : sb_q.pop_front();
      check("read.data", 32'(rd_data), 32'(exp_b));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check_state("read");
      $display("read %02h count=%0d", exp_b, count);
   endtask

   initial begin
      total = 0;
      bad = 0;
      exp_overrun = 1'b0;
      rst_n = 1'b0;
      rx_data = 8'h00;
      rx_dr = 1'b0;
      rd_en = 1'b0;
      overrun_clr = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;

      // 1: idle after reset
      repeat (5) step();
      check("t1.go", 32'(rx_go), 32'd1);
      check_state("t1");

      // 2: single byte then read
      send_byte(8'h41, 1'b0);
      read_byte();

      // 3: fill, overflow, drain, clear
      for (int i = 1; i <= Depth; i++) send_byte(8'(i), 1'b0);
      check("t3.full", 32'(full), 32'd1);
      send_byte(8'hFF, 1'b0);
      check("t3.overrun", 32'(overrun), 32'd1);
      for (int i = 0; i < Depth; i++) read_byte();
      send_byte(8'h77, 1'b0);
      read_byte();
      overrun_clr = 1'b1;
      exp_overrun = 1'b0;
      step();
      overrun_clr = 1'b0;
      check_state("t3.clr");

      // 4: full plus simultaneous capture and read
      for (int i = 0; i < Depth; i++) send_byte(8'h80 + 8'(i), 1'b0);
      send_byte(8'hAA, 1'b1);
      check("t4.count", 32'(count), 32'(Depth));
      for (int i = 0; i < Depth; i++) read_byte();
      check("t4.empty", 32'(empty), 32'd1);

      // 5: empty plus simultaneous capture and read
      send_byte(8'h55, 1'b1);
      check("t5.data", 32'(rd_data), 32'h55);
      read_byte();

      // 6: asynchronous reset with data held
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      exp_overrun = 1'b0;
      check("t6.go", 32'(rx_go), 32'd1);
      check_state("t6.rst");
      step();
      rst_n = 1'b1;
      step();
      read_byte();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
